cpu_bus_decoder: RTL
====================

Name: cpu_bus_decoder

Overview:
- Sits directly downstream of the CPU core bus master.
- Consumes the one-cycle request pulses the master issues on the CPU bus, decodes address[31:28] into a device ID, and forwards the transaction to exactly one device port.
- Returns that device's ack and read data to the master.
- Guarantees every request is acked: unmapped IDs and stalled devices are terminated locally and recorded in a sticky error capture.

Parameters:
- NUM_DEVICES, 8, number of device ports; IDs 0..NUM_DEVICES-1 are mapped, all others unmapped.
- TIMEOUT_CYCLES, 1023, maximum cycles spent in S_WAIT before forced termination; valid range 1..65535.
- UNMAPPED_RDATA, 32'h0000_0000, rdata returned on unmapped access or timeout.

Ports:
- sys.clk  in  1  system clock (if_system.sys)
- sys.reset  in  1  synchronous active-high reset (if_system.sys)
- cpu_request  in  1  single-cycle request pulse from bus master
- cpu_address  in  32  byte address, valid with cpu_request
- cpu_wdata  in  32  write data, valid with cpu_request
- cpu_wmask  in  4  byte write strobes; 0 = read
- cpu_ack  out  1  single-cycle completion pulse
- cpu_rdata  out  32  read data, valid with cpu_ack, held until next ack
- dev_request  out  NUM_DEVICES  one-hot single-cycle request pulse
- dev_address  out  32  latched address, shared by all devices
- dev_wdata  out  32  latched write data, shared
- dev_wmask  out  4  latched strobes, shared
- dev_ack  in  NUM_DEVICES  per-device completion pulse
- dev_rdata  in  NUM_DEVICES*32  per-device read data, slice i = device i
- bus_error  out  1  sticky error flag
- error_address  out  32  address of the first erroring access since last clear
- error_clear  in  1  clears bus_error

Behaviour:
- Reset values: cpu_ack=0, cpu_rdata=0, dev_request=0, dev_address/wdata/wmask=0, bus_error=0, error_address=0, state S_IDLE, timer=0, selected ID=0.
- All outputs are registered. dev_request and cpu_ack default to 0 every cycle and are pulsed only as described below.
- S_IDLE, cpu_request=1:
  - Latch address, wdata, wmask and id=address[31:28].
  - id<NUM_DEVICES: dev_request[id]=1 next cycle, clear timer, go to S_WAIT.
  - Otherwise: cpu_ack=1 and cpu_rdata=UNMAPPED_RDATA next cycle, stay in S_IDLE, set bus_error and capture error_address if not already set.
- S_WAIT, each cycle:
  - dev_ack[id]=1: cpu_ack=1 and cpu_rdata=dev_rdata[id] next cycle, go to S_IDLE.
  - Else timer increments. When timer==TIMEOUT_CYCLES-1 with no ack: cpu_ack=1, cpu_rdata=UNMAPPED_RDATA, set bus_error and capture error_address if not set, go to S_IDLE.
  - Ack and timeout in the same cycle: ack wins, no error.
- Latency:
  - Request at cycle N gives dev_request at N+1.
  - dev_ack at cycle M gives cpu_ack at M+1.
  - Unmapped request at N gives cpu_ack at N+1.
  - Minimum mapped round trip: dev_ack at N+2, cpu_ack at N+3.
- Ignored inputs:
  - dev_ack from any non-selected device, and any dev_ack while in S_IDLE (late ack after timeout), are ignored.
  - cpu_request while in S_WAIT is ignored; the master never issues one before ack.
- Error capture:
  - error_address holds the first error only; later errors do not overwrite it while bus_error=1.
  - error_clear and a new error in the same cycle: the new error wins; bus_error stays 1 and error_address takes the new address.
- Reset mid-transaction: returns to S_IDLE on the next edge with no cpu_ack issued. Devices must tolerate an abandoned request.
- dev_address/wdata/wmask stay stable from the latch until the next accepted request.
- Timer width is 16 bits.

Decomposition:
- Shared package sc64: the device ID enum (ID_CPU_FLASH etc.) and the NUM_CPU_DEVICES constant. Parameter defaults reference these.
- e_decoder_state enum {S_IDLE, S_WAIT} stays local to the module.
- No sub-module needed. The timeout counter is inline, about 20 lines.

Test Plan:
- Read from ID 2: request with address 0x2000_0010, wmask 0. Device 2 acks 3 cycles after dev_request with rdata 0xCAFE_F00D. Expect dev_request=8'b0000_0100 for exactly 1 cycle, dev_address=0x2000_0010, cpu_ack 1 cycle after dev_ack, cpu_rdata=0xCAFE_F00D, bus_error=0.
- Write to ID 0: address 0x0000_0004, wdata 0x1234_5678, wmask 4'b0011. Expect the same values on dev_* and cpu_ack after device 0 acks. A device 5 ack pulse injected during the wait must not complete the transaction.
- Unmapped: address 0xF000_0000. Expect cpu_ack at N+1, rdata 0, bus_error=1, error_address=0xF000_0000. A second unmapped access to 0xE000_0000 leaves error_address unchanged. Pulsing error_clear clears bus_error.
- Timeout with TIMEOUT_CYCLES=16: ID 1 never acks. Expect cpu_ack exactly 16 cycles after dev_request, rdata=UNMAPPED_RDATA, bus_error=1. A later dev_ack[1] produces no cpu_ack.
- Boundary: dev_ack[1] arrives in the same cycle the timer reaches its limit. Expect normal completion with device rdata and bus_error=0.
- Reset: assert reset 2 cycles into S_WAIT. Expect all outputs 0 the next cycle and no cpu_ack. The next request to ID 3 completes normally.

Source files
------------

// File: rtl/cpu_bus_decoder_pkg.sv
// Shared CPU-side address map: device IDs taken from address[31:28].
package sc64;

    typedef enum logic [3:0] {
        ID_CPU_FLASH,
        ID_CPU_RAM,
        ID_CPU_CFG,
        ID_CPU_USB,
        ID_CPU_SD,
        ID_CPU_SI,
        ID_CPU_PI,
        ID_CPU_DD
    } e_cpu_id;

    localparam int unsigned NUM_CPU_DEVICES = 8;

endpackage

// File: rtl/if_system.sv
// System clock and synchronous active-high reset bundle.
interface if_system;

    logic clk;
    logic reset;

    modport sys (
        input clk,
        input reset
    );

endinterface

// File: rtl/cpu_bus_decoder.sv
// Routes single-cycle CPU requests to one of NUM_DEVICES ports by address[31:28],
// terminating unmapped or stalled accesses locally with a sticky error capture.
module cpu_bus_decoder
    import sc64::*;
#(
    parameter int unsigned NUM_DEVICES    = NUM_CPU_DEVICES,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] UNMAPPED_RDATA = 32'h0000_0000
) (
    if_system.sys                   sys,

    input  logic                    cpu_request,
    input  logic [31:0]             cpu_address,
    input  logic [31:0]             cpu_wdata,
    input  logic [3:0]              cpu_wmask,
    output logic                    cpu_ack,
    output logic [31:0]             cpu_rdata,

    output logic [NUM_DEVICES-1:0]  dev_request,
    output logic [31:0]             dev_address,
    output logic [31:0]             dev_wdata,
    output logic [3:0]              dev_wmask,
    input  logic [NUM_DEVICES-1:0]  dev_ack,
    input  logic [NUM_DEVICES*32-1:0] dev_rdata,

    output logic                    bus_error,
    output logic [31:0]             error_address,
    input  logic                    error_clear
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } e_decoder_state;

    localparam logic [15:0] TIMER_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    e_decoder_state         state_q;
    logic [3:0]             id_q;
    logic [15:0]            timer_q;
    logic                   cpu_ack_q;
    logic [31:0]            cpu_rdata_q;
    logic [NUM_DEVICES-1:0] dev_request_q;
    logic [31:0]            dev_address_q;
    logic [31:0]            dev_wdata_q;
    logic [3:0]             dev_wmask_q;
    logic                   bus_error_q;
    logic                   bus_error_d;
    logic [31:0]            error_address_q;
    logic [31:0]            error_address_d;

    logic [3:0]             req_id;
    logic [NUM_DEVICES-1:0] req_onehot;
    logic                   req_mapped;
    logic                   sel_ack;
    logic [31:0]            sel_rdata;
    logic                   timer_expired;
    logic                   err_set;
    logic [31:0]            err_addr;

    assign req_id = cpu_address[31:28];

    always_comb begin
        req_onehot = '0;
        sel_ack    = 1'b0;
        sel_rdata  = '0;
        for (int unsigned i = 0; i < NUM_DEVICES; i++) begin
            req_onehot[i] = (req_id == 4'(i));
            if (id_q == 4'(i)) begin
                sel_ack   = dev_ack[i];
                sel_rdata = dev_rdata[i*32 +: 32];
            end
        end
    end

    assign req_mapped    = |req_onehot;
    assign timer_expired = (timer_q == TIMER_LIMIT);

    // A same-cycle ack always beats the timeout, so only an un-acked expiry is an error.
    assign err_set  = ((state_q == S_IDLE) && cpu_request && !req_mapped) ||
                      ((state_q == S_WAIT) && !sel_ack && timer_expired);
    assign err_addr = (state_q == S_IDLE) ? cpu_address : dev_address_q;

    always_comb begin
        bus_error_d     = bus_error_q && !error_clear;
        error_address_d = error_address_q;
        if (err_set) begin
            bus_error_d = 1'b1;
            if (!bus_error_q || error_clear) begin
                error_address_d = err_addr;
            end
        end
    end

    always_ff @(posedge sys.clk) begin
        if (sys.reset) begin
            state_q         <= S_IDLE;
            id_q            <= '0;
            timer_q         <= '0;
            cpu_ack_q       <= 1'b0;
            cpu_rdata_q     <= '0;
            dev_request_q   <= '0;
            dev_address_q   <= '0;
            dev_wdata_q     <= '0;
            dev_wmask_q     <= '0;
            bus_error_q     <= 1'b0;
            error_address_q <= '0;
        end else begin
            cpu_ack_q       <= 1'b0;
            dev_request_q   <= '0;
            bus_error_q     <= bus_error_d;
            error_address_q <= error_address_d;

            case (state_q)
                S_IDLE: begin
                    if (cpu_request) begin
                        dev_address_q <= cpu_address;
                        dev_wdata_q   <= cpu_wdata;
                        dev_wmask_q   <= cpu_wmask;
                        id_q          <= req_id;
                        if (req_mapped) begin
                            dev_request_q <= req_onehot;
                            timer_q       <= '0;
                            state_q       <= S_WAIT;
                        end else begin
                            cpu_ack_q   <= 1'b1;
                            cpu_rdata_q <= UNMAPPED_RDATA;
                        end
                    end
                end

                S_WAIT: begin
                    if (sel_ack) begin
                        cpu_ack_q   <= 1'b1;
                        cpu_rdata_q <= sel_rdata;
                        state_q     <= S_IDLE;
                    end else if (timer_expired) begin
                        cpu_ack_q   <= 1'b1;
                        cpu_rdata_q <= UNMAPPED_RDATA;
                        state_q     <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_ack       = cpu_ack_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign dev_request   = dev_request_q;
    assign dev_address   = dev_address_q;
    assign dev_wdata     = dev_wdata_q;
    assign dev_wmask     = dev_wmask_q;
    assign bus_error     = bus_error_q;
    assign error_address = error_address_q;

endmodule
